addsub_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one instance of the team's 5-bit `addsub` datapath between two independent requesters.
- Each requester issues add or subtract operations over a valid/ready request channel and receives S, Cout and Ov over a valid/ready response channel.
- Sits between the two operand-producing blocks and the single `addsub`, which it instantiates internally.
- One operation in flight at a time.

---
 rtl/addsub_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_addsub_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter/sequencer sharing one 5-bit addsub
// datapath between two requesters.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   req{0,1}_valid/ready          request handshake per requester
//   req{0,1}_a/b                  operands, WIDTH bits
//   req{0,1}_sub                  0 = A+B, 1 = A-B
//   rsp{0,1}_valid/ready          response handshake per requester
//   rsp{0,1}_s/cout/ov            sum/difference, carry out, signed overflow
//   busy                          operation in progress (state != IDLE)
//   grant                         requester owning the current/last operation
//
// One operation is in flight at a time: IDLE -> EXEC (1 cycle) -> RESP.

// addsub: shared WIDTH-bit adder/subtractor.
//   A, BC   operands; AS selects subtract (A + ~BC + 1)
//   S, Cout result and carry out (Cout=1 on subtract means no borrow)
//   Ov      signed two's-complement overflow
module addsub #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] BC,
  input  logic             AS,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ov
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  always_comb begin
    b_eff = AS ? ~BC : BC;
    sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, AS};
    S     = sum[WIDTH-1:0];
    Cout  = sum[WIDTH];
    // Overflow: operand signs agree (B after inversion) but result sign differs.
    Ov    = (A[WIDTH-1] == b_eff[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
  end

endmodule

module addsub_arbiter #(
  parameter int WIDTH     = 5,
  parameter int PRIO_INIT = 0
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_cout,
  output logic             rsp0_ov,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_cout,
  output logic             rsp1_ov,

  output logic             busy,
  output logic             grant
);

  if (WIDTH != 5) begin : g_width_check
    $error("addsub_arbiter: only WIDTH=5 is supported");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic PRIO_RST = (PRIO_INIT != 0);

  state_t state, state_nxt;

  logic             prio;
  logic             winner;
  logic             accept;
  logic             rsp_done;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;

  logic [WIDTH-1:0] res_s;
  logic             res_cout;
  logic             res_ov;

  logic [WIDTH-1:0] alu_s;
  logic             alu_cout;
  logic             alu_ov;

  // Arbitration: a lone requester always wins; on contention prio decides.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) begin
      winner = prio;
    end else begin
      winner = req1_valid;
    end
  end

  assign accept   = (state == IDLE) && (req0_valid || req1_valid);
  assign rsp_done = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state != IDLE);
    if (state == IDLE) begin
      req0_ready = req0_valid && !winner;
      req1_ready = winner;
    end
    if (state == RESP) begin
      rsp0_valid = !grant;
      rsp1_valid = grant;
    end
  end

  // Result data is only presented on the owner's channel.
  always_comb begin
    rsp0_s    = '0;
    rsp0_cout = 1'b0;
    rsp0_ov   = 1'b0;
    rsp1_s    = '0;
    rsp1_cout = 1'b0;
    rsp1_ov   = 1'b0;
    if (grant) begin
      rsp1_s    = res_s;
      rsp1_cout = res_cout;
      rsp1_ov   = res_ov;
    end else begin
      rsp0_s    = res_s;
      rsp0_cout = res_cout;
      rsp0_ov   = res_ov;
    end
  end

  // Operand capture, grant/priority bookkeeping and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_sub   <= 1'b0;
      grant    <= 1'b0;
      prio     <= PRIO_RST;
      res_s    <= '0;
      res_cout <= 1'b0;
      res_ov   <= 1'b0;
    end else begin
      if (accept) begin
        grant  <= winner;
        op_a   <= winner ? req1_a   : req0_a;
        op_b   <= winner ? req1_b   : req0_b;
        op_sub <= winner ? req1_sub : req0_sub;
      end
      if (state == EXEC) begin
        res_s    <= alu_s;
        res_cout <= alu_cout;
        res_ov   <= alu_ov;
      end
      if (rsp_done) begin
        prio <= ~grant;
      end
    end
  end

  addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .A   (op_a),
    .BC  (op_b),
    .AS  (op_sub),
    .S   (alu_s),
    .Cout(alu_cout),
    .Ov  (alu_ov)
  );

endmodule

// File: tb/tb_addsub_arbiter.sv
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_sub;
  logic [4:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [4:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp0_cout, rsp0_ov;
  logic [4:0] rsp0_s;
  logic       rsp1_valid, rsp1_ready, rsp1_cout, rsp1_ov;
  logic [4:0] rsp1_s;
  logic       busy, grant;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0] q0[$];
  logic [6:0] q1[$];
  int         acc_id[$];
  int         acc_cyc[$];

  addsub_arbiter #(
    .WIDTH    (5),
    .PRIO_INIT(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_sub  (req0_sub),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_sub  (req1_sub),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_s    (rsp0_s),
    .rsp0_cout (rsp0_cout),
    .rsp0_ov   (rsp0_ov),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_s    (rsp1_s),
    .rsp1_cout (rsp1_cout),
    .rsp1_ov   (rsp1_ov),
    .busy      (busy),
    .grant     (grant)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic from integer math: returns {ov, cout, s}.
  function automatic logic [6:0] model(input logic [4:0] a, input logic [4:0] b,
                                       input logic sub);
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    logic [4:0] s;
    logic c;
    logic o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r = sa - sb;
      c = (ua >= ub);
      s = 5'(ua - ub);
    end else begin
      r = sa + sb;
      c = ((ua + ub) >= 32);
      s = 5'(ua + ub);
    end
    o = (r > 15) || (r < -16);
    return {o, c, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on request handshake, pop/compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        q0.push_back(model(req0_a, req0_b, req0_sub));
        acc_id.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(model(req1_a, req1_b, req1_sub));
        acc_id.push_back(1);
        acc_cyc.push_back(cyc);
      end
      if (rsp0_valid && rsp0_ready) begin
        chk("rsp0_pending", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) chk("rsp0_data", 32'({rsp0_ov, rsp0_cout, rsp0_s}), 32'(q0.pop_front()));
        chk("rsp0_excl", 32'(rsp1_valid), 32'd0);
        chk("rsp0_grant", 32'(grant), 32'd0);
      end
      if (rsp1_valid && rsp1_ready) begin
        chk("rsp1_pending", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) chk("rsp1_data", 32'({rsp1_ov, rsp1_cout, rsp1_s}), 32'(q1.pop_front()));
        chk("rsp1_excl", 32'(rsp0_valid), 32'd0);
        chk("rsp1_grant", 32'(grant), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input int id, input logic [4:0] a, input logic [4:0] b,
                       input logic sub);
    int n;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id == 0 ? req0_ready : req1_ready) && n < 40) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(id == 0 ? req0_ready : req1_ready), 32'd1);
    tick();
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] held;
    int n;

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) tick();

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Basic add from requester 0 with latency checks.
    req0_a = 5'b00110; req0_b = 5'b00001; req0_sub = 1'b0; req0_valid = 1'b1;
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_rsp0", 32'(rsp0_valid), 32'd0);
    tick();
    chk("t1_resp_rsp0", 32'(rsp0_valid), 32'd1);
    chk("t1_resp_val", 32'({rsp0_ov, rsp0_cout, rsp0_s}), 32'(7'b0000111));
    tick();
    chk("t1_done_busy", 32'(busy), 32'd0);

    // Requester 1: subtract, then add with overflow.
    issue(1, 5'b00010, 5'b01111, 1'b1);
    wait_idle();
    issue(1, 5'b11011, 5'b10100, 1'b0);
    tick();
    chk("t2_ov_val", 32'({rsp1_ov, rsp1_cout, rsp1_s}), 32'(7'b1101111));
    wait_idle();
    chk("t2_grant_kept", 32'(grant), 32'd1);

    // Fairness: both requesters valid continuously from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc_id.delete(); acc_cyc.delete();
    req0_a = 5'd3; req0_b = 5'd4; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 5'd9; req1_b = 5'd2; req1_sub = 1'b1; req1_valid = 1'b1;
    n = 0;
    while (acc_id.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("fair_count", 32'(acc_id.size()), 32'd4);
    for (int i = 0; i < acc_id.size(); i++) chk("fair_id", 32'(acc_id[i]), 32'(i % 2));
    for (int i = 1; i < acc_cyc.size(); i++) chk("fair_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    wait_idle();

    // Back-pressure on rsp0 while requester 1 waits.
    rsp0_ready = 1'b0;
    held = model(5'd5, 5'd9, 1'b1);
    issue(0, 5'd5, 5'd9, 1'b1);
    req1_a = 5'd1; req1_b = 5'd1; req1_sub = 1'b0; req1_valid = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_rsp0_s", 32'(rsp0_s), 32'(held[4:0]));
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    chk("bp_req1_accept", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    wait_idle();

    // Reset during EXEC: discard op, then reissue.
    req0_a = 5'd7; req0_b = 5'd8; req0_sub = 1'b0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("rx_exec_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_rsp0", 32'(rsp0_valid), 32'd0);
    q0.delete();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rx_no_rsp0", 32'(rsp0_valid), 32'd0);
    issue(0, 5'd7, 5'd8, 1'b0);
    wait_idle();

    // Reset during RESP: grant and prio return to reset values.
    rsp1_ready = 1'b0;
    issue(1, 5'd20, 5'd3, 1'b1);
    tick();
    chk("rr_resp_rsp1", 32'(rsp1_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_rsp1", 32'(rsp1_valid), 32'd0);
    chk("rr_grant", 32'(grant), 32'd0);
    q1.delete();
    tick();
    rst = 1'b0;
    rsp1_ready = 1'b1;
    req0_a = 5'd1; req0_b = 5'd2; req0_sub = 1'b0; req0_valid = 1'b1;
    req1_a = 5'd3; req1_b = 5'd4; req1_sub = 1'b0; req1_valid = 1'b1;
    #1;
    chk("rr_prio_req0", 32'(req0_ready), 32'd1);
    chk("rr_prio_req1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Lone requester 1 served back to back.
    acc_id.delete(); acc_cyc.delete();
    req1_a = 5'd15; req1_b = 5'd1; req1_sub = 1'b0; req1_valid = 1'b1;
    n = 0;
    while (acc_id.size() < 3 && n < 60) begin
      tick();
      n++;
    end
    req1_valid = 1'b0;
    chk("lone_count", 32'(acc_id.size()), 32'd3);
    for (int i = 0; i < acc_id.size(); i++) chk("lone_id", 32'(acc_id[i]), 32'd1);
    for (int i = 1; i < acc_cyc.size(); i++) chk("lone_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    wait_idle();
    tick();

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
